// File: rtl/modulo_negar_matriz_param.sv
// Registered LED-matrix frame transformer: pass-through, invert, timed blink
// and masked inversion. A loaded frame is held in dado_r. Every output is taken
// straight from a register, so no input reaches an output combinationally.
module modulo_negar_matriz_param #(
    parameter int WIDTH     = 35,
    parameter int BLINK_DIV = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] m_at,
    input  logic [WIDTH-1:0] mascara,
    input  logic [1:0]       modo,
    input  logic             carregar,
    output logic [WIDTH-1:0] N_m_at,
    output logic             fase,
    output logic             pronto
);

    // The counter is at least one bit wide, even when BLINK_DIV is 1.
    localparam int CW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(BLINK_DIV - 1);

    localparam logic [1:0] MODO_PASS  = 2'b00;
    localparam logic [1:0] MODO_INV   = 2'b01;
    localparam logic [1:0] MODO_BLINK = 2'b10;
    localparam logic [1:0] MODO_MASK  = 2'b11;

    logic [WIDTH-1:0] dado_r;
    logic [WIDTH-1:0] n_m_at_r;
    logic [CW-1:0]    cnt_r;
    logic             fase_r;
    logic             pronto_r;

    logic [WIDTH-1:0] dado_n_s;
    logic [WIDTH-1:0] n_m_at_n_s;
    logic [CW-1:0]    cnt_n_s;
    logic             fase_n_s;

    // Applies the selected mode to a frame. The caller passes next-state
    // values, so a new frame, mode or phase shows on the edge that produces it.
    function automatic logic [WIDTH-1:0] transform(
        input logic [1:0]       md,
        input logic             ph,
        input logic [WIDTH-1:0] fr,
        input logic [WIDTH-1:0] mk
    );
        logic [WIDTH-1:0] res;
        case (md)
            MODO_PASS:  res = fr;
            MODO_INV:   res = ~fr;
            MODO_BLINK: res = ph ? ~fr : fr;
            MODO_MASK:  res = fr ^ mk;
            default:    res = fr;
        endcase
        return res;
    endfunction

    // Next-state logic: frame capture, blink counter/phase and transformed output
    always_comb begin
        dado_n_s   = dado_r;
        cnt_n_s    = {CW{1'b0}};
        fase_n_s   = 1'b0;
        n_m_at_n_s = {WIDTH{1'b0}};

        if (carregar) begin
            dado_n_s = m_at;
        end else begin
            dado_n_s = dado_r;
        end

        // Outside blink mode the counter and phase stay cleared. Re-entering
        // blink mode therefore starts a full normal half-period.
        if (modo == MODO_BLINK) begin
            if (cnt_r == CNT_LAST) begin
                cnt_n_s  = {CW{1'b0}};
                fase_n_s = ~fase_r;
            end else begin
                cnt_n_s  = cnt_r + CW'(1);
                fase_n_s = fase_r;
            end
        end else begin
            cnt_n_s  = {CW{1'b0}};
            fase_n_s = 1'b0;
        end

        n_m_at_n_s = transform(modo, fase_n_s, dado_n_s, mascara);
    end

    // State and output registers; synchronous reset overrides a concurrent load
    always_ff @(posedge clk) begin
        if (rst) begin
            dado_r   <= {WIDTH{1'b0}};
            cnt_r    <= {CW{1'b0}};
            fase_r   <= 1'b0;
            pronto_r <= 1'b0;
            n_m_at_r <= {WIDTH{1'b0}};
        end else begin
            dado_r   <= dado_n_s;
            cnt_r    <= cnt_n_s;
            fase_r   <= fase_n_s;
            pronto_r <= carregar;
            n_m_at_r <= n_m_at_n_s;
        end
    end

    assign N_m_at = n_m_at_r;
    assign fase   = fase_r;
    assign pronto = pronto_r;

endmodule
